// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq: registered SEL_W-to-2^SEL_W active-low one-hot decoder
// with a three-enable gate and a scan sequencer. The scan sequencer sweeps the
// address through every output and holds each one for DWELL cycles. A sweep is
// either one-shot or wrapping.
//
// Handshake: the block has no valid/ready pair. `start` is a level sampled only
// in IDLE with mode=1 and the enables active. `done` is a one-cycle pulse that
// the consumer must catch on the cycle it is high.
module decoder_scan_seq #(
    parameter int SEL_W = 3,
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  g1,
    input  logic                  g2a_n,
    input  logic                  g2b_n,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  mode,
    input  logic                  start,
    input  logic                  wrap,
    output logic [2**SEL_W-1:0]   dec_out_n,
    output logic [SEL_W-1:0]      addr,
    output logic                  busy,
    output logic                  done
);

    localparam int OUT_W   = 2**SEL_W;
    localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [OUT_W-1:0]   ALL_ONES = '1;
    localparam logic [DWELL_W-1:0] LAST_DWELL = DWELL_W'(DWELL - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t               state, state_nx;
    logic [DWELL_W-1:0]   dwell_cnt, dwell_nx;
    logic [SEL_W-1:0]     addr_nx;
    logic [OUT_W-1:0]     dec_nx;
    logic                 done_nx;
    logic                 en;

    // Active-low one-hot pattern for a given address.
    function automatic logic [OUT_W-1:0] onehot_n(input logic [SEL_W-1:0] a);
        logic [OUT_W-1:0] one;
        one = OUT_W'(1);
        return ~(one << a);
    endfunction

    assign en = g1 & ~g2a_n & ~g2b_n;

    // State and output registers. Reset is asynchronous, so the outputs clear
    // without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            addr      <= '0;
            dec_out_n <= ALL_ONES;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            dwell_cnt <= dwell_nx;
            addr      <= addr_nx;
            dec_out_n <= dec_nx;
            busy      <= (state_nx == SCAN);
            done      <= done_nx;
        end
    end

    // Next-state, next-address and next-output decode. The outputs are blank
    // and frozen unless a branch below says otherwise.
    always_comb begin
        state_nx = state;
        dwell_nx = dwell_cnt;
        addr_nx  = addr;
        dec_nx   = ALL_ONES;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (!mode) begin
                    addr_nx = sel;
                    dec_nx  = en ? onehot_n(sel) : ALL_ONES;
                end else if (start && en) begin
                    state_nx = SCAN;
                    addr_nx  = '0;
                    dwell_nx = '0;
                    dec_nx   = onehot_n('0);
                end
            end
            SCAN: begin
                if (!mode) begin
                    // An abort hands control straight back to direct decode.
                    state_nx = IDLE;
                    addr_nx  = sel;
                    dec_nx   = en ? onehot_n(sel) : ALL_ONES;
                end else if (en) begin
                    if (dwell_cnt == LAST_DWELL) begin
                        dwell_nx = '0;
                        if (addr == '1) begin
                            if (wrap) begin
                                addr_nx = '0;
                                dec_nx  = onehot_n('0);
                            end else begin
                                // The one-shot sweep ends here. addr keeps the
                                // last address that was swept.
                                state_nx = IDLE;
                                done_nx  = 1'b1;
                            end
                        end else begin
                            addr_nx = addr + 1'b1;
                            dec_nx  = onehot_n(addr + 1'b1);
                        end
                    end else begin
                        dwell_nx = dwell_cnt + 1'b1;
                        dec_nx   = onehot_n(addr);
                    end
                end
                // With en low the outputs are blanked. addr and dwell_cnt hold,
                // so the sweep resumes where it paused.
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Self-checking bench for decoder_scan_seq. It drives two instances from the
// same inputs: the default (SEL_W=3, DWELL=4) and a small one (SEL_W=2,
// DWELL=1). A sweep-position reference model predicts every registered output.
module tb_decoder_scan_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       g1 = 1'b0, g2a_n = 1'b1, g2b_n = 1'b1;
  logic [2:0] sel = '0;
  logic       mode = 1'b0, start = 1'b0, wrap = 1'b0;

  logic [7:0] dec0;
  logic [2:0] addr0;
  logic       busy0, done0;
  logic [3:0] dec1;
  logic [1:0] addr1;
  logic       busy1, done1;

  int n_checks = 0;
  int n_fail = 0;

  logic [20:0] exp_q[$];
  logic [20:0] e;
  wire  [20:0] obs = {dec0, addr0, busy0, done0, dec1, addr1, busy1, done1};
  localparam logic [20:0] RESET_VEC = {8'hFF, 3'd0, 1'b0, 1'b0, 4'hF, 2'd0, 1'b0, 1'b0};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  decoder_scan_seq #(.SEL_W(3), .DWELL(4)) dut0 (
    .clk(clk), .reset(reset), .g1(g1), .g2a_n(g2a_n), .g2b_n(g2b_n),
    .sel(sel), .mode(mode), .start(start), .wrap(wrap),
    .dec_out_n(dec0), .addr(addr0), .busy(busy0), .done(done0)
  );

  decoder_scan_seq #(.SEL_W(2), .DWELL(1)) dut1 (
    .clk(clk), .reset(reset), .g1(g1), .g2a_n(g2a_n), .g2b_n(g2b_n),
    .sel(sel[1:0]), .mode(mode), .start(start), .wrap(wrap),
    .dec_out_n(dec1), .addr(addr1), .busy(busy1), .done(done1)
  );

  // ---------------- reference model ----------------
  // Each scan is tracked as a position 0 .. OUT_W*DWELL-1 along the sweep.
  // The address is position / DWELL.
  int         sw[2] = '{3, 2};
  int         dw[2] = '{4, 1};
  bit         m_scan[2];
  int         m_pos[2];
  int         m_addr[2];
  logic [7:0] m_dec[2];
  bit         m_done[2];

  function automatic logic [7:0] dec_of(input int a);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << a);
  endfunction

  task automatic model_step();
    bit en;
    int s;
    en = g1 & ~g2a_n & ~g2b_n;
    for (int i = 0; i < 2; i++) begin
      s = (i == 0) ? int'(sel) : int'(sel[1:0]);
      if (reset) begin
        m_scan[i] = 0; m_pos[i] = 0; m_addr[i] = 0; m_dec[i] = 8'hFF; m_done[i] = 0;
      end else begin
        m_done[i] = 0;
        if (m_scan[i] && mode && en) begin
          m_pos[i]++;
          if (m_pos[i] == (1 << sw[i]) * dw[i]) begin
            if (wrap) m_pos[i] = 0;
            else begin m_scan[i] = 0; m_done[i] = 1; end
          end
          if (m_scan[i]) begin
            m_addr[i] = m_pos[i] / dw[i];
            m_dec[i]  = dec_of(m_addr[i]);
          end else m_dec[i] = 8'hFF;
        end else if (m_scan[i] && mode) begin
          m_dec[i] = 8'hFF;
        end else if (!mode) begin
          m_scan[i] = 0;
          m_addr[i] = s;
          m_dec[i]  = en ? dec_of(s) : 8'hFF;
        end else if (start && en) begin
          m_scan[i] = 1; m_pos[i] = 0; m_addr[i] = 0; m_dec[i] = dec_of(0);
        end else begin
          m_dec[i] = 8'hFF;
        end
      end
    end
    exp_q.push_back({m_dec[0], 3'(m_addr[0]), m_scan[0], m_done[0],
                     m_dec[1][3:0], 2'(m_addr[1]), m_scan[1], m_done[1]});
  endtask

  // ---------------- driver ----------------
  // One clock: the model samples the inputs at the rising edge, and the DUT is
  // observed at the following falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_en(input logic [2:0] v);
    {g1, g2a_n, g2b_n} = v;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      tick();
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL reset model: got %h want %h", obs, e); end
      n_checks++;
      if (obs !== RESET_VEC) begin n_fail++; $display("FAIL reset value: got %h want %h", obs, RESET_VEC); end
    end
    reset = 1'b0;
  endtask

  task automatic test_direct();
    logic [7:0] one = 8'd1;
    mode = 1'b0; set_en(3'b100);
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      tick();
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL direct sel=%0d: got %h want %h", s, obs, e); end
      n_checks++;
      if (dec0 !== ~(one << s) || addr0 !== 3'(s))
        begin n_fail++; $display("FAIL direct decode sel=%0d: got %h/%0d want %h/%0d", s, dec0, addr0, ~(one << s), s); end
    end
  endtask

  task automatic test_disabled();
    logic [2:0] pat[4] = '{3'b000, 3'b110, 3'b101, 3'b111};
    mode = 1'b0; sel = 3'd3;
    for (int k = 0; k < 4; k++) begin
      set_en(pat[k]);
      tick();
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL disabled en=%b: got %h want %h", pat[k], obs, e); end
      n_checks++;
      if (dec0 !== 8'hFF) begin n_fail++; $display("FAIL disabled dec en=%b: got %h want ff", pat[k], dec0); end
    end
    set_en(3'b100);
  endtask

  task automatic test_one_shot();
    int nb0 = 0, nd0 = 0, nb1 = 0, nd1 = 0;
    mode = 1'b1; wrap = 1'b0; start = 1'b1;
    for (int k = 0; k < 41; k++) begin
      tick();
      start = 1'b0;
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL one_shot cyc=%0d: got %h want %h", k, obs, e); end
      nb0 += busy0; nd0 += done0; nb1 += busy1; nd1 += done1;
    end
    n_checks++;
    if (nb0 != 32 || nd0 != 1 || nb1 != 4 || nd1 != 1)
      begin n_fail++; $display("FAIL one_shot counts: got busy %0d/%0d done %0d/%0d want 32/4 1/1", nb0, nb1, nd0, nd1); end
  endtask

  task automatic test_wrap();
    int nd0 = 0, nd1 = 0;
    mode = 1'b1; wrap = 1'b1; start = 1'b1;
    for (int k = 0; k < 70; k++) begin
      tick();
      start = 1'b0;
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL wrap cyc=%0d: got %h want %h", k, obs, e); end
      if (k == 32) begin
        n_checks++;
        if (dec0 !== 8'hFE || addr0 !== 3'd0 || busy0 !== 1'b1)
          begin n_fail++; $display("FAIL wrap return: got %h/%0d/%b want fe/0/1", dec0, addr0, busy0); end
      end
      nd0 += done0; nd1 += done1;
    end
    n_checks++;
    if (nd0 != 0 || nd1 != 0) begin n_fail++; $display("FAIL wrap done: got %0d/%0d want 0/0", nd0, nd1); end
    wrap = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL wrap_end cyc=%0d: got %h want %h", k, obs, e); end
      nd0 += done0; nd1 += done1;
    end
    n_checks++;
    if (nd0 != 1 || nd1 != 1 || busy0 !== 1'b0)
      begin n_fail++; $display("FAIL wrap_end done: got %0d/%0d busy %b want 1/1 0", nd0, nd1, busy0); end
  endtask

  task automatic test_pause();
    int nb0 = 0, nd0 = 0;
    mode = 1'b1; wrap = 1'b0; start = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (k >= 10 && k < 13) set_en(3'b000); else set_en(3'b100);
      tick();
      start = 1'b0;
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL pause cyc=%0d: got %h want %h", k, obs, e); end
      if (k == 9) begin
        n_checks++;
        if (addr0 !== 3'd2 || dec0 !== 8'hFB) begin n_fail++; $display("FAIL pause point: got %0d/%h want 2/fb", addr0, dec0); end
      end
      if (k >= 10 && k < 13) begin
        n_checks++;
        if (dec0 !== 8'hFF || addr0 !== 3'd2) begin n_fail++; $display("FAIL pause blank: got %h/%0d want ff/2", dec0, addr0); end
      end
      nb0 += busy0; nd0 += done0;
    end
    n_checks++;
    if (nb0 != 35 || nd0 != 1) begin n_fail++; $display("FAIL pause busy: got %0d done %0d want 35 1", nb0, nd0); end
  endtask

  task automatic test_abort();
    mode = 1'b1; wrap = 1'b1; start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 6) mode = 1'b0;
      sel = 3'd5;
      tick();
      start = 1'b0;
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL abort cyc=%0d: got %h want %h", k, obs, e); end
      if (k == 6) begin
        n_checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || dec0 !== 8'hDF)
          begin n_fail++; $display("FAIL abort edge: got busy %b done %b dec %h want 0 0 df", busy0, done0, dec0); end
      end
    end
  endtask

  task automatic test_async_reset();
    mode = 1'b1; wrap = 1'b1; start = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      start = 1'b0;
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL pre_reset cyc=%0d: got %h want %h", k, obs, e); end
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== RESET_VEC) begin n_fail++; $display("FAIL async_reset: got %h want %h", obs, RESET_VEC); end
    tick();
    e = exp_q.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_hold: got %h want %h", obs, e); end
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      g1    = ($urandom_range(0, 7) != 0);
      g2a_n = ($urandom_range(0, 15) == 0);
      g2b_n = ($urandom_range(0, 15) == 0);
      mode  = ($urandom_range(0, 15) != 0);
      start = ($urandom_range(0, 3) == 0);
      wrap  = ($urandom_range(0, 1) == 1);
      sel   = 3'($urandom_range(0, 7));
      tick();
      e = exp_q.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL random cyc=%0d: got %h want %h", k, obs, e); end
      n_checks++;
      if ($countones(~dec0) > 1 || $countones(~dec1) > 1)
        begin n_fail++; $display("FAIL onehot cyc=%0d: got %h/%h want at most one low bit", k, dec0, dec1); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_direct();
    test_disabled();
    test_one_shot();
    test_wrap();
    test_pause();
    test_abort();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
